// File: rtl/report_fifo_rd_pkg.sv
// Shared constants, write-source encoding and overflow arithmetic for the
// target-report read FIFO.
package report_fifo_rd_pkg;

  // Upper half of every end-of-frame marker word.
  localparam logic [15:0] EOF_TAG_DEF = 16'hEEEE;

  // Bit positions inside rd_state = {full, almost_full, empty}.
  localparam int ST_EMPTY = 0;
  localparam int ST_AFULL = 1;
  localparam int ST_FULL  = 2;

  // Saturation ceiling of the dropped-write counter.
  localparam logic [7:0] OVF_MAX = 8'hFF;

  // Which word, if any, competes for the RAM write port this cycle.
  typedef enum logic [1:0] {
    SRC_NONE,       // nothing to store
    SRC_DATA,       // wr_data from the detection pipeline
    SRC_MARK_NOW,   // marker for a sweep_end arriving this cycle
    SRC_MARK_PEND   // marker deferred from the previous cycle
  } wr_src_e;

  // Adds up to three drop events to the overflow counter without wrapping.
  function automatic logic [7:0] ovf_add(input logic [7:0] cnt,
                                         input logic [1:0] inc);
    logic [8:0] sum;
    sum = {1'b0, cnt} + {7'b0, inc};
    return (sum > {1'b0, OVF_MAX}) ? OVF_MAX : sum[7:0];
  endfunction

endpackage

// File: rtl/report_fifo_rd_sdp_ram.sv
// Simple dual-port RAM with registered read; maps onto RAM4K9 blocks.
// One write port and one read port, both on the same clock.
module sdp_ram #(
  parameter int AW = 9,
  parameter int DW = 33
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] q
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  // Write port and registered read port. A read and write to the same
  // address on the same edge returns the old word, which is what a full
  // FIFO doing pop+push needs.
  // NOTE: the array has no reset; block RAM cannot be cleared in one cycle
  // and the FIFO pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) q <= mem[raddr];
  end

endmodule

// File: rtl/report_fifo_rd.sv
// Target-report FIFO: buffers detection words, inserts an end-of-frame
// marker on each sweep end and hands one word to the PCI register block per
// rising edge of the host read request.
module report_fifo_rd
  import report_fifo_rd_pkg::*;
#(
  parameter int          DEPTH_LOG2  = 9,
  parameter int          AFULL_LEVEL = 448,
  parameter logic [15:0] EOF_TAG     = EOF_TAG_DEF
) (
  input  logic                  pclk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [31:0]           wr_data,
  input  logic                  sweep_end,
  input  logic                  flush,
  input  logic                  rd_en,
  output logic [31:0]           rd_data,
  output logic                  rd_stb,
  output logic [2:0]            rd_state,
  output logic                  done,
  output logic [DEPTH_LOG2:0]   level,
  output logic [7:0]            ovf_cnt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LW    = DEPTH_LOG2 + 1;
  // Bit 32 tags marker words so the EOF counter never mistakes a data word
  // whose upper half happens to equal EOF_TAG; it fits in the spare bits of
  // the 36-bit-wide RAM4K9 arrangement.
  localparam int DW    = 33;

  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0]         eof_cnt;
  logic                  mk_pend;
  logic [15:0]           mk_seq, frame_seq;
  logic                  rd_en_d, req, pop_d;
  logic [DW-1:0]         ram_q;

  logic                  full, empty, pop, can_wr, push;
  logic                  mark_wr, mark_pop, set_pend, seq_adv;
  logic [1:0]            ovf_inc;
  logic [DW-1:0]         wword;
  wr_src_e               src;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);

  assign rd_state[ST_EMPTY] = empty;
  assign rd_state[ST_AFULL] = (level >= LW'(AFULL_LEVEL));
  assign rd_state[ST_FULL]  = full;
  assign done               = (eof_cnt != '0);

  assign mark_pop = pop_d && ram_q[DW-1];

  // Arbitrate the single write port between data, a fresh marker and a
  // deferred marker, and count every word that loses.
  // NOTE: every output of this block is given a default first so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    src      = SRC_NONE;
    ovf_inc  = '0;
    seq_adv  = 1'b0;
    set_pend = 1'b0;
    pop      = req && !empty;
    can_wr   = !full || pop;

    if (mk_pend) begin
      // The deferred marker owns this cycle; anything else arriving is lost.
      src = SRC_MARK_PEND;
      if (wr_en) ovf_inc = ovf_inc + 2'd1;
      if (sweep_end) begin
        ovf_inc = ovf_inc + 2'd1;
        seq_adv = 1'b1;
      end
    end else if (wr_en) begin
      src = SRC_DATA;
      if (sweep_end) begin
        set_pend = 1'b1;
        seq_adv  = 1'b1;
      end
    end else if (sweep_end) begin
      src     = SRC_MARK_NOW;
      seq_adv = 1'b1;
    end

    push    = (src != SRC_NONE) && can_wr;
    mark_wr = push && (src == SRC_MARK_NOW || src == SRC_MARK_PEND);
    if (src != SRC_NONE && !can_wr) ovf_inc = ovf_inc + 2'd1;

    case (src)
      SRC_DATA:      wword = {1'b0, wr_data};
      SRC_MARK_NOW:  wword = {1'b1, EOF_TAG, frame_seq};
      SRC_MARK_PEND: wword = {1'b1, EOF_TAG, mk_seq};
      default:       wword = '0;
    endcase
  end

  sdp_ram #(
    .AW (DEPTH_LOG2),
    .DW (DW)
  ) u_ram (
    .clk   (pclk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wword),
    .re    (pop),
    .raddr (rd_ptr),
    .q     (ram_q)
  );

  // Request edge register; it keeps tracking rd_en through a flush so a
  // level held across the flush is not mistaken for a new request.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge pclk) begin
    if (rst) rd_en_d <= 1'b0;
    else     rd_en_d <= rd_en;
  end

  // FIFO pointers, occupancy, EOF count and the read pipeline
  // (edge detect -> pop/RAM read -> registered rd_data with strobe).
  always_ff @(posedge pclk) begin
    if (rst || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      eof_cnt <= '0;
      mk_pend <= 1'b0;
      mk_seq  <= '0;
      req     <= 1'b0;
      pop_d   <= 1'b0;
      rd_data <= '0;
      rd_stb  <= 1'b0;
    end else begin
      req    <= rd_en && !rd_en_d;
      pop_d  <= pop;
      rd_stb <= pop_d;
      if (pop_d) rd_data <= ram_q[31:0];

      if (push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);

      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: ;
      endcase

      case ({mark_wr, mark_pop})
        2'b10:   eof_cnt <= eof_cnt + LW'(1);
        2'b01:   eof_cnt <= eof_cnt - LW'(1);
        default: ;
      endcase

      mk_pend <= set_pend;
      if (set_pend) mk_seq <= frame_seq;
    end
  end

  // Frame sequence and drop counter survive a flush; only rst clears them.
  always_ff @(posedge pclk) begin
    if (rst) begin
      frame_seq <= '0;
      ovf_cnt   <= '0;
    end else if (!flush) begin
      if (seq_adv) frame_seq <= frame_seq + 16'd1;
      ovf_cnt <= ovf_add(ovf_cnt, ovf_inc);
    end
  end

endmodule

// File: tb/tb_report_fifo_rd.sv
// Self-checking bench for report_fifo_rd: a vector table for the basic
// frame read-out, hand sequences for fill/overflow/request/flush/wrap, and a
// randomized run against a queue-based reference model.
module tb_report_fifo_rd;

  localparam int DEPTH = 512;
  localparam int AFULL = 448;
  localparam logic [15:0] TAG = 16'hEEEE;

  logic        pclk = 1'b0;
  logic        rst, wr_en, sweep_end, flush, rd_en;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        rd_stb, done;
  logic [2:0]  rd_state;
  logic [9:0]  level;
  logic [7:0]  ovf_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  report_fifo_rd dut (
    .pclk      (pclk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .sweep_end (sweep_end),
    .flush     (flush),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_stb    (rd_stb),
    .rd_state  (rd_state),
    .done      (done),
    .level     (level),
    .ovf_cnt   (ovf_cnt)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Advance one clock; outputs are read and inputs driven 1 ns after the edge.
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // ---------------- reference model ----------------
  logic [32:0] mq[$];          // stored words, bit 32 = marker
  int          m_ovf, m_seq;
  bit          m_pend;
  logic [15:0] m_pend_seq;
  bit          m_prev_rd, m_req, m_fly_v, m_stb;
  logic [32:0] m_fly;
  logic [31:0] m_rd_data;

  function automatic void model_reset();
    mq.delete();
    m_ovf = 0; m_seq = 0; m_pend = 0; m_pend_seq = '0;
    m_prev_rd = 0; m_req = 0; m_fly_v = 0; m_stb = 0;
    m_fly = '0; m_rd_data = '0;
  endfunction

  // Effect of one clock edge given the inputs sampled at that edge.
  function automatic void model_edge(bit we, logic [31:0] wd, bit se,
                                     bit fl, bit re);
    int          drops = 0;
    bit          popping, room, have = 0;
    logic [32:0] item = '0;
    if (fl) begin
      mq.delete();
      m_pend = 0; m_fly_v = 0; m_req = 0; m_stb = 0; m_rd_data = '0;
      m_prev_rd = re;
      return;
    end
    m_stb = m_fly_v;
    if (m_fly_v) m_rd_data = m_fly[31:0];
    popping = m_req && (mq.size() != 0);
    room    = (mq.size() < DEPTH) || popping;
    if (m_pend) begin
      item = {1'b1, TAG, m_pend_seq}; have = 1; m_pend = 0;
      if (we) drops++;
      if (se) begin drops++; m_seq = (m_seq + 1) % 65536; end
    end else if (we) begin
      item = {1'b0, wd}; have = 1;
      if (se) begin
        m_pend = 1; m_pend_seq = 16'(m_seq); m_seq = (m_seq + 1) % 65536;
      end
    end else if (se) begin
      item = {1'b1, TAG, 16'(m_seq)}; have = 1; m_seq = (m_seq + 1) % 65536;
    end
    m_fly_v = popping;
    if (popping) m_fly = mq.pop_front();
    if (have) begin
      if (room) mq.push_back(item);
      else      drops++;
    end
    m_ovf = (m_ovf + drops > 255) ? 255 : m_ovf + drops;
    m_req = re && !m_prev_rd;
    m_prev_rd = re;
  endfunction

  // Frames still held: markers queued plus a marker on its way to rd_data.
  function automatic int model_marks();
    int n = 0;
    foreach (mq[i]) if (mq[i][32]) n++;
    if (m_fly_v && m_fly[32]) n++;
    return n;
  endfunction

  task automatic compare_model(input int cyc);
    int sz;
    sz = mq.size();
    check($sformatf("rnd%0d level", cyc), level, sz);
    check($sformatf("rnd%0d rd_state", cyc), rd_state,
          {sz == DEPTH, sz >= AFULL, sz == 0});
    check($sformatf("rnd%0d done", cyc), done, model_marks() != 0);
    check($sformatf("rnd%0d ovf_cnt", cyc), ovf_cnt, m_ovf);
    check($sformatf("rnd%0d rd_stb", cyc), rd_stb, m_stb);
    check($sformatf("rnd%0d rd_data", cyc), rd_data, m_rd_data);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          rst, we, se, re;
    logic [31:0] wd;
    int          lvl;
    logic [2:0]  st;
    bit          dn, stb;
    logic [31:0] data;
  } vec_t;

  vec_t vecs[$];

  function automatic void row(bit r, bit we, logic [31:0] wd, bit se, bit re,
                              int lvl, logic [2:0] st, bit dn, bit stb,
                              logic [31:0] data);
    vec_t v;
    v.rst = r; v.we = we; v.wd = wd; v.se = se; v.re = re;
    v.lvl = lvl; v.st = st; v.dn = dn; v.stb = stb; v.data = data;
    vecs.push_back(v);
  endfunction

  task automatic do_reset();
    rst = 1; wr_en = 0; wr_data = '0; sweep_end = 0; flush = 0; rd_en = 0;
    tick(); tick();
    rst = 0;
    model_reset();
  endtask

  // Issue one read request (0->1->0) and let the pipeline settle,
  // returning how many strobes appeared and the last strobed word.
  task automatic pulse_read(output int stbs, output logic [31:0] last);
    stbs = 0; last = '0;
    rd_en = 1; tick();
    rd_en = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rd_stb) begin stbs++; last = rd_data; end
    end
  endtask

  initial begin
    int          stbs, got_n, max_lvl, wp;
    logic [31:0] last;
    logic [31:0] exp_q[$];

    // --- reset state ---
    do_reset();
    check("rst level", level, 0);
    check("rst rd_state", rd_state, 3'b001);
    check("rst done", done, 0);
    check("rst rd_stb", rd_stb, 0);
    check("rst rd_data", rd_data, 0);
    check("rst ovf_cnt", ovf_cnt, 0);

    // --- table: 3 words + marker read out; data+sweep_end same cycle ---
    //   rst we data          se re  lvl st     dn stb data
    row(0, 1, 32'hA0, 0, 0, 1, 3'b000, 0, 0, 32'h0);
    row(0, 1, 32'hA1, 0, 0, 2, 3'b000, 0, 0, 32'h0);
    row(0, 1, 32'hA2, 0, 0, 3, 3'b000, 0, 0, 32'h0);
    row(0, 0, 32'h00, 1, 0, 4, 3'b000, 1, 0, 32'h0);
    row(0, 0, 32'h00, 0, 0, 4, 3'b000, 1, 0, 32'h0);
    row(0, 0, 32'h00, 0, 1, 4, 3'b000, 1, 0, 32'h0);
    row(0, 0, 32'h00, 0, 0, 3, 3'b000, 1, 0, 32'h0);
    row(0, 0, 32'h00, 0, 1, 3, 3'b000, 1, 1, 32'hA0);
    row(0, 0, 32'h00, 0, 0, 2, 3'b000, 1, 0, 32'hA0);
    row(0, 0, 32'h00, 0, 1, 2, 3'b000, 1, 1, 32'hA1);
    row(0, 0, 32'h00, 0, 0, 1, 3'b000, 1, 0, 32'hA1);
    row(0, 0, 32'h00, 0, 1, 1, 3'b000, 1, 1, 32'hA2);
    row(0, 0, 32'h00, 0, 0, 0, 3'b001, 1, 0, 32'hA2);
    row(0, 0, 32'h00, 0, 0, 0, 3'b001, 0, 1, 32'hEEEE0000);
    row(0, 0, 32'h00, 0, 0, 0, 3'b001, 0, 0, 32'hEEEE0000);
    row(1, 0, 32'h00, 0, 0, 0, 3'b001, 0, 0, 32'h0);
    row(0, 1, 32'h12345678, 1, 0, 1, 3'b000, 0, 0, 32'h0);
    row(0, 0, 32'h00, 0, 0, 2, 3'b000, 1, 0, 32'h0);
    row(0, 0, 32'h00, 0, 1, 2, 3'b000, 1, 0, 32'h0);
    row(0, 0, 32'h00, 0, 0, 1, 3'b000, 1, 0, 32'h0);
    row(0, 0, 32'h00, 0, 1, 1, 3'b000, 1, 1, 32'h12345678);
    row(0, 0, 32'h00, 0, 0, 0, 3'b001, 1, 0, 32'h12345678);
    row(0, 0, 32'h00, 0, 0, 0, 3'b001, 0, 1, 32'hEEEE0000);
    row(0, 0, 32'h00, 0, 0, 0, 3'b001, 0, 0, 32'hEEEE0000);

    foreach (vecs[i]) begin
      rst = vecs[i].rst; wr_en = vecs[i].we; wr_data = vecs[i].wd;
      sweep_end = vecs[i].se; rd_en = vecs[i].re; flush = 0;
      tick();
      check($sformatf("vec%0d level", i), level, vecs[i].lvl);
      check($sformatf("vec%0d rd_state", i), rd_state, vecs[i].st);
      check($sformatf("vec%0d done", i), done, vecs[i].dn);
      check($sformatf("vec%0d rd_stb", i), rd_stb, vecs[i].stb);
      check($sformatf("vec%0d rd_data", i), rd_data, vecs[i].data);
    end

    // --- fill to full, almost-full threshold, overflow saturation ---
    do_reset();
    wr_en = 1;
    for (int i = 0; i < AFULL - 1; i++) begin wr_data = i; tick(); end
    check("fill447 level", level, AFULL - 1);
    check("fill447 rd_state", rd_state, 3'b000);
    wr_data = AFULL - 1; tick();
    check("fill448 rd_state", rd_state, 3'b010);
    for (int i = AFULL; i < DEPTH; i++) begin wr_data = i; tick(); end
    check("full level", level, DEPTH);
    check("full rd_state", rd_state, 3'b110);
    check("full ovf_cnt", ovf_cnt, 0);
    for (int i = 0; i < 300; i++) begin wr_data = 32'hBAD0_0000 + i; tick(); end
    check("ovf saturate", ovf_cnt, 255);
    check("ovf level", level, DEPTH);
    wr_en = 0; rd_en = 1; tick();
    rd_en = 0; wr_en = 1; wr_data = 32'hDEAD0001; tick();
    check("pop+push full level", level, DEPTH);
    wr_en = 0; tick();
    check("pop+push rd_stb", rd_stb, 1);
    check("pop+push rd_data", rd_data, 0);

    // --- held-high request pops once; request while empty is ignored ---
    do_reset();
    wr_en = 1;
    for (int i = 0; i < 5; i++) begin wr_data = 100 + i; tick(); end
    wr_en = 0; rd_en = 1; stbs = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 10) rd_en = 0;
      tick();
      if (rd_stb) stbs++;
    end
    check("held stb count", stbs, 1);
    check("held level", level, 4);
    check("held rd_data", rd_data, 100);
    got_n = 0;
    for (int i = 0; i < 4; i++) begin pulse_read(stbs, last); got_n += stbs; end
    check("drain stb count", got_n, 4);
    check("drain rd_data", rd_data, 104);
    check("drain rd_state", rd_state, 3'b001);
    pulse_read(stbs, last);
    check("empty read stb", stbs, 0);
    check("empty read rd_data", rd_data, 104);

    // --- flush cancels an in-flight pop; frame_seq survives flush ---
    do_reset();
    sweep_end = 1; tick();
    sweep_end = 0; wr_en = 1; wr_data = 32'h55; tick();
    wr_en = 0; rd_en = 1; tick();
    rd_en = 0; flush = 1; stbs = 0; tick();
    if (rd_stb) stbs++;
    flush = 0;
    for (int i = 0; i < 3; i++) begin tick(); if (rd_stb) stbs++; end
    check("flush stb", stbs, 0);
    check("flush level", level, 0);
    check("flush done", done, 0);
    sweep_end = 1; tick();
    sweep_end = 0; tick();
    check("post-flush level", level, 1);
    pulse_read(stbs, last);
    check("post-flush stb", stbs, 1);
    check("post-flush marker", last, 32'hEEEE0001);

    // --- pointer wrap with alternating push/pop ---
    do_reset();
    got_n = 0; max_lvl = 0;
    for (int k = 0; k < 1206; k++) begin
      if (k < 1200 && k % 2 == 0) begin
        wr_en = 1; wr_data = 32'hA000_0000 + k / 2; rd_en = 1;
        exp_q.push_back(32'hA000_0000 + k / 2);
      end else begin
        wr_en = 0; rd_en = 0;
      end
      tick();
      if (int'(level) > max_lvl) max_lvl = int'(level);
      if (rd_stb) begin
        got_n++;
        if (exp_q.size() == 0) check("wrap extra word", rd_data, 0);
        else check($sformatf("wrap word%0d", got_n), rd_data, exp_q.pop_front());
      end
    end
    check("wrap word count", got_n, 600);
    check("wrap max level", max_lvl, 1);

    // --- randomized run against the reference model ---
    do_reset();
    for (int c = 0; c < 5000; c++) begin
      case ((c / 1000) % 4)
        0:       wp = 90;
        1:       wp = 0;
        2:       wp = 40;
        default: wp = 70;
      endcase
      wr_en     = ($urandom_range(0, 99) < wp);
      wr_data   = $urandom;
      sweep_end = ($urandom_range(0, 99) < 4);
      flush     = ($urandom_range(0, 299) == 0);
      rd_en     = $urandom_range(0, 1);
      model_edge(wr_en, wr_data, sweep_end, flush, rd_en);
      tick();
      compare_model(c);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
